// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle MULT/MULTU/DIV/DIVU engine that owns HI/LO and stalls
//            HI/LO consumers while an operation is in flight.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    input  logic             i_rd_hilo,
    input  logic             i_wr_hi,
    input  logic             i_wr_lo,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int c_CNT_W = $clog2(WIDTH);
    localparam int c_ACC_W = 2 * WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_ACC_W-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opnd;
    logic                 r_is_div;
    logic                 r_neg_lo;
    logic                 r_neg_hi;
    logic                 r_div_zero;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_idle;
    logic                 w_accept;
    logic                 w_is_div;
    logic                 w_divisor_zero;
    logic                 w_sgn1;
    logic                 w_sgn2;
    logic [WIDTH-1:0]     w_mag1;
    logic [WIDTH-1:0]     w_mag2;
    logic [WIDTH:0]       w_mul_sum;
    logic [c_ACC_W-1:0]   w_mul_next;
    logic [c_ACC_W-1:0]   w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH:0]       w_div_diff;
    logic [c_ACC_W-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    assign w_idle         = (r_state == S_IDLE);
    assign w_accept       = w_idle && i_start && !i_cancel;
    assign w_is_div       = i_op[1];
    assign w_divisor_zero = (i_op2 == '0);
    assign w_sgn1         = i_op[0] && i_op1[WIDTH-1];
    assign w_sgn2         = i_op[0] && i_op2[WIDTH-1];
    assign w_mag1         = w_sgn1 ? -i_op1 : i_op1;
    assign w_mag2         = w_sgn2 ? -i_op2 : i_op2;

    assign o_busy     = !w_idle;
    assign o_stall    = o_busy && (i_rd_hilo || i_wr_hi || i_wr_lo || i_start);
    assign o_done     = (r_state == S_FIX) && !i_cancel;
    assign o_div_zero = o_done && r_div_zero;
    assign o_hi       = r_hi;
    assign o_lo       = r_lo;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (w_is_div && w_divisor_zero) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_FIX;
                end
            end
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (i_cancel) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Multiply: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    // Divide: shift {remainder, quotient} left and subtract the divisor when it fits (restoring).
    always_comb begin
        w_mul_sum   = r_acc[c_ACC_W-1:WIDTH] + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_mul_next  = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
        w_div_shift = {r_acc[2*WIDTH-1:0], 1'b0};
        w_div_ge    = (w_div_shift[c_ACC_W-1:WIDTH] >= {1'b0, r_opnd});
        w_div_diff  = w_div_shift[c_ACC_W-1:WIDTH] - {1'b0, r_opnd};
        w_div_next  = w_div_ge ? {w_div_diff, w_div_shift[WIDTH-1:1], 1'b1} : w_div_shift;
    end

    // Sign fix-up: product/quotient take the operand sign xor, remainder takes the dividend sign.
    always_comb begin
        w_prod   = r_neg_lo ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
        w_quot   = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem    = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_res_hi = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_is_div   <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_div_zero <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= c_CNT_INIT;
            r_is_div   <= w_is_div;
            r_neg_lo   <= w_sgn1 ^ w_sgn2;
            r_neg_hi   <= w_is_div && w_sgn1;
            r_div_zero <= w_is_div && w_divisor_zero;
            r_opnd     <= w_is_div ? w_mag2 : w_mag1;
            r_acc      <= {{(WIDTH + 1){1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
        end else if ((r_state == S_RUN) && !i_cancel) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end

    // HI/LO: result write in FIX, MTHI/MTLO only in IDLE; a start or a cancel drops the move.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!i_cancel) begin
            if (r_state == S_FIX) begin
                if (!r_div_zero) begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
            end else if (w_idle && !i_start) begin
                if (i_wr_hi) begin
                    r_hi <= i_wdata;
                end
                if (i_wr_lo) begin
                    r_lo <= i_wdata;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Randomized and directed checks of muldiv_sequencer against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int WIDTH = 32;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic             i_rd_hilo;
    logic             i_wr_hi;
    logic             i_wr_lo;
    logic [WIDTH-1:0] i_wdata;
    logic             i_cancel;
    logic             o_busy;
    logic             o_stall;
    logic             o_done;
    logic             o_div_zero;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;
    logic        exp_dz   = 1'b0;

    muldiv_sequencer #(.WIDTH(WIDTH)) u_dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_op1      (i_op1),
        .i_op2      (i_op2),
        .i_rd_hilo  (i_rd_hilo),
        .i_wr_hi    (i_wr_hi),
        .i_wr_lo    (i_wr_lo),
        .i_wdata    (i_wdata),
        .i_cancel   (i_cancel),
        .o_busy     (o_busy),
        .o_stall    (o_stall),
        .o_done     (o_done),
        .o_div_zero (o_div_zero),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        exp_dz = 1'b0;
        case (op)
            2'b00: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'b01: begin
                p = 64'(sa * sb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    exp_dz = 1'b1;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    exp_dz = 1'b1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = 32'(q);
                    m_hi = 32'(r);
                end
            end
        endcase
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return 32'($urandom());
        endcase
    endfunction

    // Called just after a falling edge with the unit idle; returns the same way.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        model(op, a, b);
        i_start = 1'b1;
        i_op    = op;
        i_op1   = a;
        i_op2   = b;
        @(negedge i_clk);
        i_start = 1'b0;
        i_wr_hi = 1'b0;
        i_wr_lo = 1'b0;
        check({tag, " busy after start"}, 64'(o_busy), 64'd1);
        cyc = 0;
        while (!o_done && cyc < 40) begin
            @(negedge i_clk);
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), exp_dz ? 64'd0 : 64'(WIDTH));
        check({tag, " div_zero"}, 64'(o_div_zero), 64'(exp_dz));
        @(negedge i_clk);
        check({tag, " hi:lo"}, {o_hi, o_lo}, {m_hi, m_lo});
        check({tag, " idle after done"}, 64'(o_busy), 64'd0);
    endtask

    task automatic write_hilo(input logic [31:0] hi, input logic [31:0] lo);
        i_wr_hi = 1'b1;
        i_wdata = hi;
        @(negedge i_clk);
        i_wr_hi = 1'b0;
        i_wr_lo = 1'b1;
        i_wdata = lo;
        @(negedge i_clk);
        i_wr_lo = 1'b0;
        m_hi = hi;
        m_lo = lo;
        check("mthi/mtlo", {o_hi, o_lo}, {hi, lo});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          cyc;
        bit          stall_ok;
        bit          done_seen;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        i_rst = 1'b1; i_start = 1'b0; i_op = 2'b00; i_op1 = '0; i_op2 = '0;
        i_rd_hilo = 1'b0; i_wr_hi = 1'b0; i_wr_lo = 1'b0; i_wdata = '0; i_cancel = 1'b0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        check("reset busy", 64'(o_busy), 64'd0);
        check("reset stall", 64'(o_stall), 64'd0);
        check("reset done", 64'(o_done), 64'd0);
        check("reset div_zero", 64'(o_div_zero), 64'd0);
        check("reset hi:lo", {o_hi, o_lo}, 64'd0);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max");
        check("multu max const", {o_hi, o_lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, "mult -3*7");
        check("mult -3*7 const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div -7/2");
        check("div -7/2 const", {o_hi, o_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1");
        check("div min/-1 const", {o_hi, o_lo}, 64'h0000_0000_8000_0000);
        write_hilo(32'h11, 32'h22);
        run_op(2'b10, 32'd5, 32'd0, "divu 5/0");
        check("divu 5/0 const", {o_hi, o_lo}, 64'h0000_0011_0000_0022);

        // MFHI and MTLO held during a busy MULTU: stall every busy cycle, move never lands.
        model(2'b00, 32'd3, 32'd4);
        i_start = 1'b1; i_op = 2'b00; i_op1 = 32'd3; i_op2 = 32'd4;
        @(negedge i_clk);
        i_start = 1'b0; i_rd_hilo = 1'b1; i_wr_lo = 1'b1; i_wdata = 32'hDEAD_BEEF;
        cyc = 0;
        stall_ok = 1'b1;
        while (!o_done && cyc < 40) begin
            #1;
            if (!o_stall) stall_ok = 1'b0;
            @(negedge i_clk);
            cyc++;
        end
        #1;
        if (!o_stall) stall_ok = 1'b0;
        check("stall while busy", 64'(stall_ok), 64'd1);
        check("stall op latency", 64'(cyc), 64'(WIDTH));
        i_wr_lo = 1'b0;
        @(negedge i_clk);
        #1;
        check("no stall when idle", 64'(o_stall), 64'd0);
        check("mflo after stall", 64'(o_lo), 64'h0000_000C);
        check("stalled mtlo dropped", {o_hi, o_lo}, {m_hi, m_lo});
        i_rd_hilo = 1'b0;
        @(negedge i_clk);

        // Start wins over a simultaneous MTHI.
        i_wr_hi = 1'b1;
        i_wdata = 32'hCAFE_F00D;
        run_op(2'b00, 32'd6, 32'd7, "start beats mthi");

        // Cancel together with start in IDLE suppresses the start.
        i_start = 1'b1; i_cancel = 1'b1; i_op = 2'b00; i_op1 = 32'd9; i_op2 = 32'd9;
        @(negedge i_clk);
        i_start = 1'b0; i_cancel = 1'b0;
        check("cancel suppresses start", 64'(o_busy), 64'd0);

        // Cancel in the middle of RUN.
        write_hilo(32'h1234_5678, 32'h9ABC_DEF0);
        i_start = 1'b1; i_op = 2'b01; i_op1 = 32'd1000; i_op2 = 32'hFFFF_FF00;
        @(negedge i_clk);
        i_start = 1'b0;
        done_seen = 1'b0;
        repeat (9) begin
            @(negedge i_clk);
            if (o_done) done_seen = 1'b1;
        end
        i_cancel = 1'b1;
        #1;
        if (o_done) done_seen = 1'b1;
        @(negedge i_clk);
        i_cancel = 1'b0;
        check("cancel -> idle", 64'(o_busy), 64'd0);
        repeat (40) begin
            @(negedge i_clk);
            if (o_done) done_seen = 1'b1;
        end
        check("cancel no done", 64'(done_seen), 64'd0);
        check("cancel hi:lo kept", {o_hi, o_lo}, {m_hi, m_lo});

        // Reset in the middle of RUN.
        i_start = 1'b1; i_op = 2'b10; i_op1 = 32'd100; i_op2 = 32'd7;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("mid-run reset busy", 64'(o_busy), 64'd0);
        check("mid-run reset hi:lo", {o_hi, o_lo}, 64'd0);

        for (int k = 0; k < 30; k++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            run_op(op, a, b, $sformatf("rand%0d op%0d", k, op));
            if ($urandom_range(0, 4) == 0) begin
                write_hilo($urandom(), $urandom());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
